multirate_mac_pipe: RTL
=======================

// Module: multirate_mac_pipe
// PURPOSE
// - Pipelined signed-sample x unsigned-coefficient multiply-accumulate for the polyphase FIR branches.
// - Accumulates one packet of taps (in_first..in_last), then rounds, shifts and saturates the sum to an output sample.
// - Uses a valid/ready handshake on both sides, so decimator/interpolator stages can stall it without losing data.
// PARAMETERS
// - DIN0_WIDTH  16  signed sample width
// - DIN1_WIDTH  11  unsigned coefficient width; zero-extended before the multiply
// - ACC_WIDTH   32  signed accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH
// - OUT_WIDTH   16  signed output width
// - SHIFT       10  coefficient fraction bits removed at output; 1..ACC_WIDTH-1
// - NUM_STAGE   2   multiplier pipeline registers; 1..4
// PORTS
// - ap_clk     in   1           clock, rising edge
// - ap_rst_n   in   1           asynchronous active-low reset
// - in_valid   in   1           input beat valid
// - in_ready   out  1           input beat accepted when in_valid && in_ready
// - in_first   in   1           beat is the first tap of a packet
// - in_last    in   1           beat is the last tap of a packet
// - din0       in   DIN0_WIDTH  signed sample
// - din1       in   DIN1_WIDTH  unsigned coefficient
// - out_valid  out  1           result valid
// - out_ready  in   1           downstream accepts result
// - dout       out  OUT_WIDTH   rounded, saturated result
// - dout_sat   out  1           dout was clipped; qualified by out_valid
// BEHAVIOUR
// - Reset (async, asserts immediately): all stage valids=0, out_valid=0, dout=0, dout_sat=0, acc=0, acc_clear=1. In-flight packet is discarded.
// - Product: $signed(din0) * $signed({1'b0,din1}), exactly DIN0_WIDTH+DIN1_WIDTH bits.
//   Sign-extend the product to ACC_WIDTH.
// - Stall: adv = !(out_valid && !out_ready). in_ready = adv (combinational).
//   While adv=0, every pipeline register, valid and the accumulator hold.
//   Bubbles (in_valid=0) propagate as invalid stages and never touch acc.
// - Pipeline: NUM_STAGE product registers, then 1 accumulate stage. Valid, first and last flags travel with each beat.
// - Accumulate: a valid beat with (first || acc_clear) loads acc = product. Any other valid beat does acc = acc + product.
//   Overflow wraps modulo 2^ACC_WIDTH; there is no internal saturation.
//   acc_clear is set after a last beat and cleared by the next valid beat. A beat without first after a completed packet therefore starts a new packet.
// - Output: when a last beat is accumulated, form r = (acc_new + 2^(SHIFT-1)) >>> SHIFT (round half up).
//   Compute r in ACC_WIDTH+1 bits so the rounding add cannot overflow.
//   Clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. dout_sat=1 iff clamped.
//   On the same edge: load dout and dout_sat, and set out_valid=1.
// - out_valid clears on out_valid && out_ready unless a new result loads on the same edge; back-to-back results are allowed.
// - Latency: last beat accepted at edge t -> out_valid=1 after edge t+NUM_STAGE+1, with no stall.
//   Throughput is 1 beat/cycle. Packet length is >= 1 and unbounded.
// - A beat with first=1 and last=1 is a single-tap packet.
// - first=1 in mid-packet discards the partial sum and restarts. Not an error.
// - dout and dout_sat hold their value while out_valid=0. They are not cleared on handshake.
// TESTING
// - Single tap: din0=100, din1=1024, first=last=1 -> dout=100, dout_sat=0, out_valid exactly 3 cycles after accept (NUM_STAGE=2).
// - 4-tap packet: din0={1000,-2000,3000,500}, din1=512 each -> dout=1250. Repeat back-to-back 10x -> 10 results, one per 4 cycles.
// - Saturation, 8 taps:
//   din0=32767, din1=2047 -> dout=32767, dout_sat=1.
//   din0=-32768, din1=2047 -> dout=-32768, dout_sat=1.
// - Rounding:
//   din0=1, din1=512 -> dout=1.
//   din0=-1, din1=512 -> dout=0.
//   din0=-3, din1=512 -> dout=-1.
// - Backpressure: hold out_ready=0 for 5 cycles with a second packet in flight.
//   Required: in_ready=0 during the stall and dout stable; both results are delivered in order with correct values.
// - Reset mid-packet: pull ap_rst_n low after 2 of 4 beats.
//   Required: out_valid=0 immediately. Next packet {10,20} x 1024 -> dout=30.

Source files
------------

// File: rtl/multirate_mac_pipe.sv
// Signed x unsigned MAC over first..last tap packets; round/shift/saturate to one sample; last tap to out_valid = NUM_STAGE+1 cycles.
// Backpressure: a held result with out_ready low freezes every stage and drops in_ready combinationally.
module multirate_mac_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 11,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 10,
    parameter int NUM_STAGE  = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  dout,
    output logic                  dout_sat
);

    localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;
    localparam logic signed [ACC_WIDTH:0] RND_K   = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

    logic adv;
    logic load;

    logic signed [PROD_W-1:0] din0_ext;
    logic signed [PROD_W-1:0] din1_ext;
    logic signed [PROD_W-1:0] prod_in;

    logic signed [PROD_W-1:0] prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]     vld_q;
    logic [NUM_STAGE-1:0]     first_q;
    logic [NUM_STAGE-1:0]     last_q;

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        acc_clear_q, acc_clear_d;
    logic                        acc_vld_q, acc_vld_d;
    logic                        acc_last_q, acc_last_d;

    logic signed [ACC_WIDTH:0]   rnd;
    logic signed [ACC_WIDTH:0]   r;
    logic [OUT_WIDTH-1:0]        dout_q, dout_d;
    logic                        dout_sat_q, dout_sat_d;
    logic                        out_valid_q, out_valid_d;

    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv;

    // Coefficient is zero-extended so it always multiplies as a positive value.
    assign din0_ext = PROD_W'($signed(din0));
    assign din1_ext = PROD_W'({1'b0, din1});
    assign prod_in  = din0_ext * din1_ext;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
            end
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else if (adv) begin
            prod_q[0]  <= prod_in;
            vld_q[0]   <= in_valid;
            first_q[0] <= in_first;
            last_q[0]  <= in_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i]  <= prod_q[i-1];
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign prod_ext = ACC_WIDTH'(prod_q[NUM_STAGE-1]);

    // A beat following a completed packet restarts the sum even without first.
    always_comb begin
        acc_d       = acc_q;
        acc_clear_d = acc_clear_q;
        acc_vld_d   = acc_vld_q;
        acc_last_d  = acc_last_q;
        if (adv) begin
            acc_vld_d  = vld_q[NUM_STAGE-1];
            acc_last_d = last_q[NUM_STAGE-1];
            if (vld_q[NUM_STAGE-1]) begin
                if (first_q[NUM_STAGE-1] || acc_clear_q) begin
                    acc_d = prod_ext;
                end else begin
                    acc_d = acc_q + prod_ext;
                end
                acc_clear_d = last_q[NUM_STAGE-1];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            acc_clear_q <= 1'b1;
            acc_vld_q   <= 1'b0;
            acc_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_clear_q <= acc_clear_d;
            acc_vld_q   <= acc_vld_d;
            acc_last_q  <= acc_last_d;
        end
    end

    // One extra bit keeps the rounding add from wrapping at the accumulator limits.
    assign rnd  = (ACC_WIDTH + 1)'(acc_q) + RND_K;
    assign r    = rnd >>> SHIFT;
    assign load = adv && acc_vld_q && acc_last_q;

    always_comb begin
        dout_d      = dout_q;
        dout_sat_d  = dout_sat_q;
        out_valid_d = out_valid_q && !out_ready;
        if (load) begin
            out_valid_d = 1'b1;
            if (r > OUT_MAX) begin
                dout_d     = OUT_MAX[OUT_WIDTH-1:0];
                dout_sat_d = 1'b1;
            end else if (r < OUT_MIN) begin
                dout_d     = OUT_MIN[OUT_WIDTH-1:0];
                dout_sat_d = 1'b1;
            end else begin
                dout_d     = r[OUT_WIDTH-1:0];
                dout_sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dout_q      <= '0;
            dout_sat_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            dout_sat_q  <= dout_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign dout_sat  = dout_sat_q;

endmodule
